// File: rtl/eth_rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// eth_rx_frame_buffer
//
// Store-and-forward receive buffer between the framing/address-filter stage
// and the iDMA write stream. Bytes arrive on a push-only AXIS slave (no
// tready: every valid byte is consumed). Each frame is held in the buffer
// until its last byte arrives. Good frames (tuser=0 on tlast) are then
// forwarded on a ready/valid AXIS master. Bad, aborted or overflowing frames
// (and runts, when length checking is built in) are rewound out of the
// buffer and never reach the master port.
//
// Optional feature macro:
//   ETH_RX_RUNT_DROP_EN  when defined, a good frame shorter than MIN_LEN bytes
//                        is dropped. When undefined, no length counter exists
//                        and every frame of >= 1 byte ending with tuser=0 is
//                        committed.
//
// Parameters:
//   DEPTH    buffer size in bytes (power of two, >= 128)
//   MIN_LEN  runt threshold in bytes (only with ETH_RX_RUNT_DROP_EN)
//   CNT_W    width of the statistics counters
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous, active-high reset
//   s_tdata_i      received byte
//   s_tvalid_i     byte valid (consumed unconditionally)
//   s_tlast_i      last byte of frame
//   s_tuser_i      qualified by s_tlast_i: 1 = frame bad (FCS error/abort)
//   m_tdata_o      forwarded byte
//   m_tvalid_o     forwarded byte valid
//   m_tready_i     downstream ready
//   m_tlast_o      last byte of forwarded frame
//   frames_ok_o    committed frame count (wraps)
//   frames_drop_o  discarded frame count, any reason (wraps)
//   overflow_o     one-cycle pulse when a frame is dropped for lack of space
//   wr_state_o     write FSM state for debug: 0 = RECV, 1 = DROP
//
// Handshake (master port): a byte transfers on every rising edge where
// m_tvalid_o and m_tready_i are both 1. Once m_tvalid_o is raised it stays
// high, with m_tdata_o/m_tlast_o unchanged, until that transfer happens.
// -----------------------------------------------------------------------------
module eth_rx_frame_buffer #(
  parameter int DEPTH   = 2048,
  parameter int MIN_LEN = 60,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [7:0]       s_tdata_i,
  input  logic             s_tvalid_i,
  input  logic             s_tlast_i,
  input  logic             s_tuser_i,
  output logic [7:0]       m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [CNT_W-1:0] frames_ok_o,
  output logic [CNT_W-1:0] frames_drop_o,
  output logic             overflow_o,
  output logic             wr_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [PW-1:0]    PTR_DEPTH = PW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic {
    RECV = 1'b0,
    DROP = 1'b1
  } wr_state_e;

  // Buffer storage: {last, data} per byte. Not reset.
  logic [8:0] mem [DEPTH];

  // Pointers carry one extra MSB so that a completely full buffer
  // (used == DEPTH) is distinguishable from an empty one.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] used;
  logic          full;

  wr_state_e     wr_state;

  logic          beat_recv;
  logic          wr_en;
  logic          ovf_hit;
  logic          runt;
  logic          frame_bad;

  logic          rd_issue;
  logic          pop;
  logic [8:0]    rd_word;
  logic [8:0]    skid_q;
  logic          skid_vld;

  // ---------------------------------------------------------------------------
  // Occupancy. Space is only freed when the read side has fetched a byte, so
  // committed bytes are never overwritten by a later frame.
  // ---------------------------------------------------------------------------
  assign used = wr_ptr - rd_ptr;
  assign full = (used == PTR_DEPTH);

  assign beat_recv = s_tvalid_i && (wr_state == RECV);
  assign wr_en     = beat_recv && !full;
  assign ovf_hit   = beat_recv && full;

  assign wr_state_o = (wr_state == DROP);

  // ---------------------------------------------------------------------------
  // Optional runt detection. len counts bytes already written for the current
  // frame; len_inc is the length including the byte being written now, which
  // is the final length when that byte carries tlast.
  // ---------------------------------------------------------------------------
`ifdef ETH_RX_RUNT_DROP_EN
  localparam logic [15:0] MIN_LEN_16 = 16'(MIN_LEN);

  logic [15:0] len;
  logic [15:0] len_inc;

  assign len_inc = (len == 16'hFFFF) ? len : len + 16'd1;
  assign runt    = (len_inc < MIN_LEN_16);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len <= 16'd0;
    end else if (s_tvalid_i && s_tlast_i) begin
      // Any tlast beat ends the frame, whether written, dropped or ignored.
      len <= 16'd0;
    end else if (wr_en) begin
      len <= len_inc;
    end
  end
`else
  // Length is not checked in this build; MIN_LEN has no effect.
  assign runt = (MIN_LEN < 0);
`endif

  assign frame_bad = s_tuser_i || runt;

  // ---------------------------------------------------------------------------
  // Byte storage write port.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {s_tlast_i, s_tdata_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM: accepts bytes in RECV, commits or rewinds on tlast, and sits in
  // DROP swallowing the remainder of a frame that ran out of space.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state      <= RECV;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      frames_ok_o   <= '0;
      frames_drop_o <= '0;
      overflow_o    <= 1'b0;
    end else begin
      overflow_o <= ovf_hit;
      case (wr_state)
        RECV: begin
          if (s_tvalid_i) begin
            if (full) begin
              // Out of space: erase the partial frame and count it once.
              // A tlast on this very beat ends the frame, so no DROP needed.
              wr_ptr        <= commit_ptr;
              frames_drop_o <= frames_drop_o + CNT_ONE;
              if (!s_tlast_i) begin
                wr_state <= DROP;
              end
            end else if (s_tlast_i) begin
              if (frame_bad) begin
                wr_ptr        <= commit_ptr;
                frames_drop_o <= frames_drop_o + CNT_ONE;
              end else begin
                // The commit covers the byte written on this same edge.
                wr_ptr      <= wr_ptr + PTR_ONE;
                commit_ptr  <= wr_ptr + PTR_ONE;
                frames_ok_o <= frames_ok_o + CNT_ONE;
              end
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
            end
          end
        end
        DROP: begin
          if (s_tvalid_i && s_tlast_i) begin
            wr_state <= RECV;
          end
        end
        default: wr_state <= RECV;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read side. A byte is fetched whenever committed data exists and the skid
  // register is free; the fetched byte lands on the same edge in the output
  // register (if it is empty or being consumed) or otherwise in the skid. This
  // keeps the fetch decision independent of m_tready_i while still giving one
  // byte per cycle. Reads stop at commit_ptr, so they never touch the location
  // being written.
  // ---------------------------------------------------------------------------
  assign pop      = m_tvalid_o && m_tready_i;
  assign rd_issue = (rd_ptr != commit_ptr) && !skid_vld;
  assign rd_word  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr     <= '0;
      m_tvalid_o <= 1'b0;
      m_tlast_o  <= 1'b0;
      m_tdata_o  <= 8'd0;
      skid_q     <= 9'd0;
      skid_vld   <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (!m_tvalid_o || pop) begin
        // Output register is free this edge. The skid holds the older byte,
        // and no fetch happens while it is occupied.
        if (skid_vld) begin
          {m_tlast_o, m_tdata_o} <= skid_q;
          m_tvalid_o             <= 1'b1;
          skid_vld               <= 1'b0;
        end else if (rd_issue) begin
          {m_tlast_o, m_tdata_o} <= rd_word;
          m_tvalid_o             <= 1'b1;
        end else begin
          m_tvalid_o <= 1'b0;
        end
      end else if (rd_issue) begin
        // Output stalled: park the fetched byte.
        skid_q   <= rd_word;
        skid_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
`timescale 1ns/1ps
module tb_eth_rx_frame_buffer;

  // A 256-byte buffer lets three 80-byte frames queue up under a 50% ready
  // pattern while still making the overflow boundary cheap to reach.
  localparam int DEPTH   = 256;
  localparam int MIN_LEN = 60;
  localparam int CNT_W   = 16;

  // ---------------------------------------------------------------- clock/reset
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       s_tdata = 8'd0;
  logic             s_tvalid = 1'b0;
  logic             s_tlast = 1'b0;
  logic             s_tuser = 1'b0;
  logic [7:0]       m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_drop;
  logic             overflow;
  logic             wr_state;

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  eth_rx_frame_buffer #(
    .DEPTH  (DEPTH),
    .MIN_LEN(MIN_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_tdata_i    (s_tdata),
    .s_tvalid_i   (s_tvalid),
    .s_tlast_i    (s_tlast),
    .s_tuser_i    (s_tuser),
    .m_tdata_o    (m_tdata),
    .m_tvalid_o   (m_tvalid),
    .m_tready_i   (m_tready),
    .m_tlast_o    (m_tlast),
    .frames_ok_o  (frames_ok),
    .frames_drop_o(frames_drop),
    .overflow_o   (overflow),
    .wr_state_o   (wr_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int tests_run    = 0;
  int tests_failed = 0;

  logic [8:0] exp_q[$];  // {last, data} of every byte that must come out

  int beats_seen      = 0;
  int lasts_seen      = 0;
  int ovf_pulses      = 0;
  int first_valid_cyc = 0;
  bit seen_valid      = 1'b0;
  int last_beat_cyc   = 0;
  bit stall_prev      = 1'b0;
  logic [8:0] held    = 9'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- ready driver
  int rdy_mode = 0;  // 0 = low, 1 = high, 2 = random 50%
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b0;
        1:       m_tready = 1'b1;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("stall_hold", {54'd0, m_tvalid, m_tlast, m_tdata}, {54'd0, 1'b1, held});
      end
      if (m_tvalid && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (m_tvalid && m_tready) begin
        check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("beat_data", {55'd0, m_tlast, m_tdata}, {55'd0, e});
        end
        beats_seen++;
        if (m_tlast) lasts_seen++;
      end
      if (overflow) ovf_pulses++;
      stall_prev = m_tvalid && !m_tready;
      held       = {m_tlast, m_tdata};
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------- reference model
  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'((seed + i * 7 + i / 5) & 255);
  endfunction

  // Fate of a frame sent into an otherwise empty buffer.
  function automatic bit expect_commit(input int len, input bit bad);
    if (bad) return 1'b0;
    if (len > DEPTH) return 1'b0;
`ifdef ETH_RX_RUNT_DROP_EN
    if (len < MIN_LEN) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [7:0] d, input bit last, input bit user);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    s_tuser  = user;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  // tuser on non-last beats is random: it must be ignored there.
  task automatic send_frame(input int len, input bit bad, input int seed,
                            input bit push, input int gap_pct);
    if (push) begin
      for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, pat(seed, i)});
    end
    for (int i = 0; i < len; i++) begin
      int g = 0;
      while (gap_pct > 0 && g < 8 && $urandom_range(0, 99) < gap_pct) begin
        idle(1);
        g++;
      end
      if (i == len - 1) begin
        last_beat_cyc = cyc;
        beat(pat(seed, i), 1'b1, bad);
      end else begin
        beat(pat(seed, i), 1'b0, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic clear_monitor();
    beats_seen = 0;
    lasts_seen = 0;
    ovf_pulses = 0;
    seen_valid = 1'b0;
  endtask

  // Assert reset for one cycle and check every reset-cleared output.
  task automatic reset_pulse(input string name);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check({name, "_out_regs"}, {54'd0, m_tvalid, m_tlast, m_tdata}, 64'd0);
    check({name, "_ovf_state"}, {62'd0, overflow, wr_state}, 64'd0);
    check({name, "_ok_cnt"}, 64'(frames_ok), 64'd0);
    check({name, "_drop_cnt"}, 64'(frames_drop), 64'd0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    clear_monitor();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      idle(1);
      n++;
    end
    check({name, "_drain_in_time"}, 64'(n < budget), 64'd1);
    idle(4);
    check({name, "_idle_after"}, 64'(m_tvalid), 64'd0);
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    int len;
    bit bad;
    int exp_ok;
    int exp_drop;
    int exp_beats;
    int exp_ovf;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input int len, input bit bad);
    vec_t v;
    bit   c;
    c           = expect_commit(len, bad);
    v.len       = len;
    v.bad       = bad;
    v.exp_ok    = c ? 1 : 0;
    v.exp_drop  = c ? 0 : 1;
    v.exp_beats = c ? len : 0;
    v.exp_ovf   = (len > DEPTH) ? 1 : 0;
    return v;
  endfunction

  // ---------------------------------------------------------------- test body
  initial begin
    int ok_exp;
    int drop_exp;
    int n;

    vecs[0]  = mk(64, 1'b0);
    vecs[1]  = mk(1, 1'b0);
    vecs[2]  = mk(40, 1'b0);
    vecs[3]  = mk(MIN_LEN - 1, 1'b0);
    vecs[4]  = mk(MIN_LEN, 1'b0);
    vecs[5]  = mk(100, 1'b1);
    vecs[6]  = mk(1, 1'b1);
    vecs[7]  = mk(DEPTH, 1'b0);
    vecs[8]  = mk(DEPTH + 1, 1'b0);
    vecs[9]  = mk(300, 1'b0);
    vecs[10] = mk(300, 1'b1);

    // Power-on reset state.
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("por_out_regs", {54'd0, m_tvalid, m_tlast, m_tdata}, 64'd0);
    check("por_counters", {32'd0, frames_ok, frames_drop}, 64'd0);
    check("por_ovf_state", {62'd0, overflow, wr_state}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Table: one frame from a freshly reset buffer, ready held high.
    for (int r = 0; r < 11; r++) begin
      reset_pulse($sformatf("vec%0d_rst", r));
      rdy_mode = 1;
      send_frame(vecs[r].len, vecs[r].bad, r * 17, vecs[r].exp_ok != 0, 0);
      wait_drain($sformatf("vec%0d", r), 1000);
      check($sformatf("vec%0d_ok", r), 64'(frames_ok), 64'(vecs[r].exp_ok));
      check($sformatf("vec%0d_drop", r), 64'(frames_drop), 64'(vecs[r].exp_drop));
      check($sformatf("vec%0d_beats", r), 64'(beats_seen), 64'(vecs[r].exp_beats));
      check($sformatf("vec%0d_lasts", r), 64'(lasts_seen), 64'(vecs[r].exp_ok));
      check($sformatf("vec%0d_ovf", r), 64'(ovf_pulses), 64'(vecs[r].exp_ovf));
      check($sformatf("vec%0d_state", r), 64'(wr_state), 64'd0);
    end

    // First byte two cycles after the good tlast byte, then gap-free.
    reset_pulse("lat_rst");
    rdy_mode = 1;
    send_frame(64, 1'b0, 0, 1'b1, 0);
    n = 0;
    while (!seen_valid && n < 20) begin
      idle(1);
      n++;
    end
    check("lat_first_valid", 64'(first_valid_cyc), 64'(last_beat_cyc + 2));
    idle(63);
    check("lat_gap_free", 64'(beats_seen), 64'd64);
    wait_drain("lat", 200);

    // Bad 100-byte frame immediately followed by a good 64-byte frame.
    reset_pulse("bad_rst");
    rdy_mode = 1;
    send_frame(100, 1'b1, 3, 1'b0, 0);
    send_frame(64, 1'b0, 9, 1'b1, 0);
    wait_drain("bad_then_good", 500);
    check("bad_then_good_ok", 64'(frames_ok), 64'd1);
    check("bad_then_good_drop", 64'(frames_drop), 64'd1);
    check("bad_then_good_beats", 64'(beats_seen), 64'd64);

    // Overflow with ready low: drop once at byte DEPTH+1, remainder swallowed.
    reset_pulse("ovf_rst");
    rdy_mode = 0;
    for (int i = 0; i < DEPTH + 44; i++) begin
      if (i == DEPTH + 10) begin
        check("ovf_in_drop_state", 64'(wr_state), 64'd1);
        check("ovf_pulse_once_mid", 64'(ovf_pulses), 64'd1);
      end
      beat(pat(5, i), i == DEPTH + 43, 1'b0);
    end
    idle(2);
    check("ovf_pulses", 64'(ovf_pulses), 64'd1);
    check("ovf_drop", 64'(frames_drop), 64'd1);
    check("ovf_state_back", 64'(wr_state), 64'd0);
    send_frame(64, 1'b0, 21, 1'b1, 0);
    idle(5);
    check("ovf_held_valid", 64'(m_tvalid), 64'd1);
    rdy_mode = 1;
    wait_drain("ovf_next", 300);
    check("ovf_next_beats", 64'(beats_seen), 64'd64);
    check("ovf_next_ok", 64'(frames_ok), 64'd1);

    // Three back-to-back 80-byte frames against a random 50% ready.
    reset_pulse("b2b_rst");
    rdy_mode = 2;
    for (int f = 0; f < 3; f++) send_frame(80, 1'b0, 40 + f * 3, 1'b1, 0);
    wait_drain("b2b", 2000);
    check("b2b_beats", 64'(beats_seen), 64'd240);
    check("b2b_lasts", 64'(lasts_seen), 64'd3);
    check("b2b_ok", 64'(frames_ok), 64'd3);

    // Reset mid-write (byte 30) after a committed frame, then mid-readout.
    reset_pulse("rw_rst");
    rdy_mode = 1;
    send_frame(64, 1'b0, 11, 1'b1, 0);
    wait_drain("rw_pre", 300);
    for (int i = 0; i < 29; i++) beat(pat(13, i), 1'b0, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = pat(13, 29);
    reset_pulse("rw_midwrite");
    send_frame(200, 1'b0, 15, 1'b1, 0);
    n = 0;
    while (beats_seen < 20 && n < 500) begin
      idle(1);
      n++;
    end
    check("rw_readout_started", 64'(n < 500), 64'd1);
    reset_pulse("rw_midread");
    send_frame(64, 1'b0, 19, 1'b1, 0);
    wait_drain("rw_after", 300);
    check("rw_after_beats", 64'(beats_seen), 64'd64);
    check("rw_after_ok", 64'(frames_ok), 64'd1);

    // Random frames against the model; waits keep committed data within DEPTH.
    reset_pulse("rnd_rst");
    rdy_mode = 2;
    ok_exp   = 0;
    drop_exp = 0;
    for (int f = 0; f < 40; f++) begin
      int len;
      bit bad;
      bit c;
      len = $urandom_range(1, 150);
      bad = ($urandom_range(0, 3) == 0);
      c   = expect_commit(len, bad);
      n   = 0;
      while (exp_q.size() + len > DEPTH && n < 3000) begin
        idle(1);
        n++;
      end
      if (n >= 3000) check("rnd_space_wait", 64'(exp_q.size()), 64'(DEPTH - len));
      if (c) ok_exp++;
      else drop_exp++;
      send_frame(len, bad, $urandom_range(0, 255), c, 20);
      idle($urandom_range(0, 3));
    end
    wait_drain("rnd", 5000);
    check("rnd_ok", 64'(frames_ok), 64'(16'(ok_exp)));
    check("rnd_drop", 64'(frames_drop), 64'(16'(drop_exp)));
    check("rnd_lasts", 64'(lasts_seen), 64'(ok_exp));
    check("rnd_ovf", 64'(ovf_pulses), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
